// File: rtl/rsqrt_iteration_scheduler.sv
// rtl/rsqrt_iteration_scheduler.sv - sequences Newton rsqrt iterations on an external single-step core
// Optional RSQRT_EARLY_EXIT_EN: stop once successive guesses differ by at most TOLERANCE LSBs.
module rsqrt_iteration_scheduler #(
  parameter int ITERATIONS    = 4,
  parameter int FRACTION_BITS = 16,
  parameter int TOLERANCE     = 0,
  localparam int FIXED_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FIXED_WIDTH-1:0] in_number,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIXED_WIDTH-1:0] out_result,
  output logic                   out_error,
  output logic [3:0]             out_iterations,
  output logic                   core_input_valid,
  input  logic                   core_input_ready,
  output logic [FIXED_WIDTH-1:0] core_number,
  output logic [FIXED_WIDTH-1:0] core_guess,
  input  logic                   core_output_valid,
  input  logic [FIXED_WIDTH-1:0] core_new_guess
);
  localparam logic [FIXED_WIDTH-1:0] ONE     = {{(FIXED_WIDTH-1){1'b0}}, 1'b1} << FRACTION_BITS;
  localparam logic [FIXED_WIDTH-1:0] MAX_POS = {1'b0, {(FIXED_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, SEED, ISSUE, WAIT, DONE} state_t;

  state_t                  state, state_next;
  logic [FIXED_WIDTH-1:0]  number_q, number_next;
  logic [FIXED_WIDTH-1:0]  guess_q, guess_next;
  logic [FIXED_WIDTH-1:0]  seed;
  logic [3:0]              count_q, count_next, count_inc;
  logic                    error_q, error_next;
  logic                    early_exit;
  logic [5:0]              msb_index;
  logic signed [7:0]       exp_val, shift_val;
  logic [7:0]              neg_shift;

  // Seed is 2^-ceil(e/2) relative to one(), where 2^e is the leading power of two of x.
  always_comb begin
    msb_index = '0;
    for (int i = 0; i < FIXED_WIDTH; i++) begin
      if (number_q[i]) msb_index = 6'(i);
    end
    exp_val   = 8'(msb_index) - 8'(FRACTION_BITS);
    shift_val = (exp_val + 8'sd1) >>> 1;
    neg_shift = 8'(-shift_val);
    if (!shift_val[7]) begin
      seed = ONE >> shift_val[6:0];
    end else if ((FRACTION_BITS + int'(neg_shift)) >= (FIXED_WIDTH - 1)) begin
      seed = MAX_POS;
    end else begin
      seed = ONE << neg_shift;
    end
  end

`ifdef RSQRT_EARLY_EXIT_EN
  logic signed [FIXED_WIDTH:0] guess_delta;
  logic [FIXED_WIDTH:0]        guess_distance;

  always_comb begin
    guess_delta    = $signed({core_new_guess[FIXED_WIDTH-1], core_new_guess})
                   - $signed({guess_q[FIXED_WIDTH-1], guess_q});
    guess_distance = guess_delta[FIXED_WIDTH] ? (FIXED_WIDTH+1)'(-guess_delta)
                                              : (FIXED_WIDTH+1)'(guess_delta);
    early_exit     = guess_distance <= (FIXED_WIDTH+1)'(TOLERANCE);
  end
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    number_next = number_q;
    guess_next  = guess_q;
    count_next  = count_q;
    error_next  = error_q;
    count_inc   = count_q + 4'd1;
    case (state)
      IDLE: begin
        if (in_valid) begin
          number_next = in_number;
          count_next  = '0;
          error_next  = 1'b0;
          state_next  = SEED;
        end
      end
      SEED: begin
        if ($signed(number_q) <= 0) begin
          guess_next = '0;
          error_next = 1'b1;
          count_next = '0;
          state_next = DONE;
        end else begin
          guess_next = seed;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (core_input_ready) state_next = WAIT;
      end
      WAIT: begin
        if (core_output_valid) begin
          guess_next = core_new_guess;
          count_next = count_inc;
          state_next = (count_inc == 4'(ITERATIONS) || early_exit) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      number_q <= '0;
      guess_q  <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      number_q <= number_next;
      guess_q  <= guess_next;
      count_q  <= count_next;
      error_q  <= error_next;
    end
  end

  // Operand and guess registers only change in IDLE/SEED/WAIT, so they hold across ISSUE and WAIT.
  assign in_ready         = (state == IDLE);
  assign out_valid        = (state == DONE);
  assign out_result       = guess_q;
  assign out_error        = error_q;
  assign out_iterations   = count_q;
  assign core_input_valid = (state == ISSUE) && core_input_ready;
  assign core_number      = number_q;
  assign core_guess       = guess_q;
endmodule

// File: tb/tb_rsqrt_iteration_scheduler.sv
// tb/tb_rsqrt_iteration_scheduler.sv - self-checking bench for rsqrt_iteration_scheduler with a behavioural Newton core
module tb_rsqrt_iteration_scheduler;
  localparam int ITER = 4;
  localparam int FB   = 16;
  localparam int TOL  = 0;
`ifdef RSQRT_EARLY_EXIT_EN
  localparam int CONVERGED_ITERS = 1;
`else
  localparam int CONVERGED_ITERS = ITER;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_number;
  logic        out_valid, out_ready, out_error;
  logic [31:0] out_result;
  logic [3:0]  out_iterations;
  logic        core_input_valid, core_input_ready;
  logic [31:0] core_number, core_guess;
  logic        core_output_valid;
  logic [31:0] core_new_guess;

  rsqrt_iteration_scheduler #(.ITERATIONS(ITER), .FRACTION_BITS(FB), .TOLERANCE(TOL)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_number(in_number),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_error(out_error), .out_iterations(out_iterations),
    .core_input_valid(core_input_valid), .core_input_ready(core_input_ready),
    .core_number(core_number), .core_guess(core_guess),
    .core_output_valid(core_output_valid), .core_new_guess(core_new_guess)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint to_fixed(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  // g * (1.5 - 0.5 * x * g^2) in Q.FB
  function automatic longint core_step(input longint x, input longint g);
    longint xg, xg2, t;
    xg  = (x * g) >>> FB;
    xg2 = (xg * g) >>> FB;
    t   = (longint'(3) <<< (FB - 1)) - (xg2 >>> 1);
    return (g * t) >>> FB;
  endfunction

  function automatic longint seed_of(input longint x);
    longint v, r;
    int p, e, s;
    v = x;
    p = -1;
    while (v > 0) begin
      v = v >> 1;
      p++;
    end
    e = p - FB;
    s = (e > 0) ? (e + 1) / 2 : -((-e) / 2);
    if (s >= 0) return (longint'(1) << FB) >> s;
    r = (longint'(1) << FB) << (-s);
    return (r > 64'sh7fffffff) ? 64'sh7fffffff : r;
  endfunction

  typedef struct {
    logic [31:0] result;
    logic        error;
    int          iters;
  } exp_t;

  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    longint xs, g, ng, d;
    xs = longint'($signed(x));
    r.result = '0;
    r.error  = 1'b1;
    r.iters  = 0;
    if (xs <= 0) return r;
    r.error = 1'b0;
    g = seed_of(xs);
    for (int n = 0; n < ITER; n++) begin
      ng = to_fixed(core_step(xs, g));
      d  = ng - g;
      g  = ng;
      r.iters++;
`ifdef RSQRT_EARLY_EXIT_EN
      if (((d < 0) ? -d : d) <= TOL) break;
`else
      if (d == 64'sh7fffffffffffffff) break;
`endif
    end
    r.result = g[31:0];
    return r;
  endfunction

  int cycle = 0;
  initial forever begin
    @(posedge clock);
    cycle++;
  end

  // Behavioural core: fixed latency after each pulse, optional ready stall before every issue.
  int          core_latency = 1;
  int          stall_cfg = 0;
  int          stall_left = 0;
  int          pulse_count = 0;
  logic [31:0] first_guess = '0;
  logic [31:0] held_number, held_guess;
  int          delay;
  bit          pending = 0;
  bit          saw_accept, saw_output;

  initial begin
    core_input_ready  = 1'b1;
    core_output_valid = 1'b0;
    core_new_guess    = '0;
    forever begin
      @(negedge clock);
      saw_accept = 0;
      saw_output = core_output_valid;
      if (reset) begin
        pending    = 0;
        saw_output = 0;
        stall_left = 0;
      end else begin
        if (in_valid && in_ready) begin
          saw_accept  = 1;
          pulse_count = 0;
        end
        if (pending) begin
          check("core_number_stable", core_number, held_number);
          check("core_guess_stable", core_guess, held_guess);
        end
        if (core_input_valid) begin
          check("issue_only_when_ready", core_input_ready, 1);
          check("single_outstanding_issue", pending, 0);
          pulse_count++;
          if (pulse_count == 1) first_guess = core_guess;
          pending     = 1;
          delay       = core_latency;
          held_number = core_number;
          held_guess  = core_guess;
        end
      end
      @(posedge clock);
      #1;
      core_output_valid = 1'b0;
      if (pending) begin
        delay--;
        if (delay == 0) begin
          core_output_valid = 1'b1;
          core_new_guess = 32'(core_step(longint'($signed(held_number)), longint'($signed(held_guess))));
          pending = 0;
        end
      end
      if (saw_accept) stall_left = stall_cfg + 1;
      else if (saw_output) stall_left = stall_cfg;
      core_input_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
  end

  // Response scoreboard and protocol checks.
  exp_t        sb[$];
  exp_t        e;
  int          accept_cycle = 0;
  int          done_count = 0;
  bit          seen_valid = 0;
  bit          idle_next = 0;
  logic [31:0] snap_result, last_result, last_first_guess;
  logic        snap_error, last_error;
  logic [3:0]  snap_iters, last_iters;
  int          last_pulses;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      sb.delete();
      seen_valid = 0;
      idle_next  = 0;
    end else begin
      if (idle_next) begin
        check("idle_after_handshake", in_ready, 1);
        idle_next = 0;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_number));
        accept_cycle = cycle;
      end
      if (out_valid) begin
        check("in_ready_low_in_done", in_ready, 0);
        if (!seen_valid) begin
          seen_valid  = 1;
          snap_result = out_result;
          snap_error  = out_error;
          snap_iters  = out_iterations;
          if (sb.size() == 0) check("unexpected_response", 1, 0);
          else check("latency", cycle - accept_cycle,
                     2 + sb[0].iters * (core_latency + 1 + stall_cfg));
        end else begin
          check("hold_result", out_result, snap_result);
          check("hold_error", out_error, snap_error);
          check("hold_iterations", out_iterations, snap_iters);
        end
        if (out_ready) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", out_result, e.result);
            check("error", out_error, e.error);
            check("iterations", out_iterations, 4'(e.iters));
            check("core_pulses", pulse_count, e.iters);
          end
          last_result      = out_result;
          last_error       = out_error;
          last_iters       = out_iterations;
          last_pulses      = pulse_count;
          last_first_guess = first_guess;
          done_count++;
          seen_valid = 0;
          idle_next  = 1;
        end
      end
    end
  end

  task automatic run_req(input logic [31:0] x, input int lat, input int stall, input int hold);
    int start;
    bit got;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        got = 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (!got) check("in_ready_timeout", 0, 1);
    core_latency = lat;
    stall_cfg    = stall;
    out_ready    = (hold == 0);
    in_number    = x;
    in_valid     = 1'b1;
    start        = done_count;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (hold > 0) begin
      got = 0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clock);
        if (out_valid) begin
          got = 1;
          break;
        end
      end
      if (!got) check("out_valid_timeout", 0, 1);
      repeat (hold - 1) @(negedge clock);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
    end
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      if (done_count != start) begin
        got = 1;
        break;
      end
      @(posedge clock);
    end
    if (!got) check("response_timeout", 0, 1);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_number = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_error", out_error, 0);
    check("reset_out_result", out_result, 0);
    check("reset_out_iterations", out_iterations, 0);
    check("reset_core_input_valid", core_input_valid, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_req(32'h0004_0000, 1, 0, 0);
    check("x4_seed", last_first_guess, 32'h0000_8000);
    check("x4_result", last_result, 32'h0000_8000);
    check("x4_iterations", last_iters, 4'(CONVERGED_ITERS));

    run_req(32'h0000_4000, 2, 0, 0);
    check("xquarter_seed", last_first_guess, 32'h0002_0000);
    check("xquarter_result", last_result, 32'h0002_0000);

    run_req(32'h0000_0000, 1, 0, 0);
    check("xzero_error", last_error, 1);
    check("xzero_result", last_result, 0);
    check("xzero_iterations", last_iters, 0);
    check("xzero_no_issue", last_pulses, 0);

    run_req(32'hFFFF_0000, 1, 0, 0);
    check("xneg_error", last_error, 1);
    check("xneg_result", last_result, 0);
    check("xneg_no_issue", last_pulses, 0);

    run_req(32'h0001_0000, 3, 0, 10);
    check("xone_result", last_result, 32'h0001_0000);
    run_req(32'h0002_0000, 1, 5, 0);
    run_req(32'h0000_0001, 1, 0, 0);
    check("xtiny_seed", last_first_guess, 32'h0100_0000);
    run_req(32'h7FFF_FFFF, 2, 1, 3);
    check("xmax_seed", last_first_guess, 32'h0000_0200);

    // Abandon a request while the core is busy, then confirm the block recovers.
    core_latency = 8;
    stall_cfg    = 0;
    in_number    = 32'h0003_0000;
    in_valid     = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      if (pulse_count > 0) begin
        got = 1;
        break;
      end
    end
    if (!got) check("reset_test_issue_timeout", 0, 1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_error", out_error, 0);
    check("midreset_out_result", out_result, 0);
    check("midreset_out_iterations", out_iterations, 0);
    check("midreset_core_input_valid", core_input_valid, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    run_req(32'h0004_0000, 1, 0, 0);
    check("post_reset_result", last_result, 32'h0000_8000);
    check("post_reset_iterations", last_iters, 4'(CONVERGED_ITERS));

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
